seqdet_scan_arbiter: RTL and testbench

Shares a single serial "1001" sequence detector (overlapping match, Moore output) among several requesters. Each requester hands over a parallel word. The block grants requesters round-robin, clears the detector, serializes the word MSB-first into it, counts detector hits, and returns the hit count with the requester ID over a valid/ready response port. It sits between the parallel-word producers and the shared bit-serial detector datapath.

---
 rtl/seqdet_scan_arbiter_pkg.sv | 8 +
 rtl/seqdet_scan_arbiter_if.sv | 25 ++
 rtl/seqdet_scan_arbiter_det.sv | 27 ++
 rtl/seqdet_scan_arbiter.sv | 83 ++++++++
 tb/tb_seqdet_scan_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seqdet_scan_arbiter_pkg.sv
// seqdet_scan_arbiter_pkg: controller state encoding, the detected pattern and a count-width helper.
package seqdet_scan_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, RESP} state_t;
  localparam logic [3:0] PATTERN = 4'b1001;
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/seqdet_scan_arbiter_if.sv
// seqdet_scan_arbiter_if: word request bus and result response bus.
// Ports: req_valid/req_data/req_ready (per-requester words in), rsp_valid/rsp_id/rsp_count/rsp_ready (result out).
// master = producer/consumer side, slave = arbiter side.
interface seqdet_scan_arbiter_if import seqdet_scan_arbiter_pkg::*; #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8
);
  localparam int CW = count_width(WIDTH);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [CW-1:0] rsp_count;
  logic rsp_ready;
  modport master (
    output req_valid, req_data, rsp_ready,
    input req_ready, rsp_valid, rsp_id, rsp_count
  );
  modport slave (
    input req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_count
  );
endinterface

// File: rtl/seqdet_scan_arbiter_det.sv
// seq1001_det: serial "1001" detector, overlapping, Moore output.
// Ports: clock, reset (sync, active-high), I (serial bit), F (high the cycle after a completing bit).
module seq1001_det import seqdet_scan_arbiter_pkg::*; (
  input logic clock,
  input logic reset,
  input logic I,
  output logic F
);
  typedef enum logic [2:0] {S0, S1, S10, S100, S1001} det_t;
  det_t state, nxt;
  always_ff @(posedge clock)
    state <= reset ? S0 : nxt;
  // Fallbacks keep the longest pattern prefix that is still a suffix of the input;
  // from the match state the trailing '1' restarts a new match.
  always_comb begin
    nxt = S0;
    case (state)
      S0: nxt = (I == PATTERN[3]) ? S1 : S0;
      S1: nxt = (I == PATTERN[2]) ? S10 : S1;
      S10: nxt = (I == PATTERN[1]) ? S100 : S1;
      S100: nxt = (I == PATTERN[0]) ? S1001 : S0;
      S1001: nxt = I ? S1 : S10;
      default: nxt = S0;
    endcase
  end
  assign F = (state == S1001);
endmodule

// File: rtl/seqdet_scan_arbiter.sv
// seqdet_scan_arbiter: round-robin shares one serial "1001" detector among NREQ word producers.
// Ports: clock, reset (sync, active-high), bus (slave side of seqdet_scan_arbiter_if), busy (state != IDLE).
module seqdet_scan_arbiter import seqdet_scan_arbiter_pkg::*; #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8
) (
  input logic clock,
  input logic reset,
  seqdet_scan_arbiter_if.slave bus,
  output logic busy
);
  localparam int CW = count_width(WIDTH);
  localparam int IDW = $clog2(NREQ);
  state_t state, nxt;
  logic [IDW-1:0] last_grant, gsel, idx, rsp_id;
  logic gany, det_hit;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0] bit_cnt, hits;
  // First valid requester at or after last_grant+1, wrapping.
  always_comb begin
    gsel = '0;
    gany = 1'b0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NREQ);
      if (!gany && bus.req_valid[idx]) begin
        gsel = idx;
        gany = 1'b1;
      end
    end
  end
  wire take = (state == IDLE) && gany && !reset;
  assign bus.req_ready = take ? (NREQ'(1) << gsel) : '0;
  always_ff @(posedge clock)
    state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = gany ? CLEAR : IDLE;
      CLEAR: nxt = SHIFT;
      SHIFT: nxt = (bit_cnt == CW'(WIDTH - 1)) ? DRAIN : SHIFT;
      DRAIN: nxt = RESP;
      RESP: nxt = bus.rsp_ready ? IDLE : RESP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= IDW'(NREQ - 1);
      shreg <= '0;
      rsp_id <= '0;
      bit_cnt <= '0;
      hits <= '0;
    end else begin
      if (take) begin
        shreg <= WIDTH'(bus.req_data >> (WIDTH * int'(gsel)));
        rsp_id <= gsel;
        last_grant <= gsel;
      end
      if (state == CLEAR) begin
        bit_cnt <= '0;
        hits <= '0;
      end
      if (state == SHIFT) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + CW'(1);
      end
      // DRAIN picks up a match completed by the last shifted bit.
      if (state == SHIFT || state == DRAIN)
        hits <= hits + CW'(det_hit);
    end
  end
  seq1001_det u_det (
    .clock(clock),
    .reset(reset || (state == CLEAR)),
    .I((state == SHIFT) && shreg[WIDTH-1]),
    .F(det_hit)
  );
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_id = rsp_id;
  assign bus.rsp_count = hits;
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_seqdet_scan_arbiter.sv
// tb_seqdet_scan_arbiter: randomized and directed checks of seqdet_scan_arbiter against a pattern-count model.
module tb_seqdet_scan_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy;
  int vectors = 0;
  int miscompares = 0;
  int lg = NREQ - 1;
  seqdet_scan_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus();
  seqdet_scan_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave),
    .busy(busy)
  );
  always #5 clock = ~clock;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic int ref_count(input logic [WIDTH-1:0] w);
    int c = 0;
    for (int i = WIDTH - 1; i >= 3; i--)
      if (w[i -: 4] == 4'b1001) c++;
    return c;
  endfunction
  task automatic scan(input int id, input logic [WIDTH-1:0] w, output logic [NREQ-1:0] rdy,
                      output int lat, output logic [1:0] rid, output logic [3:0] rcnt);
    bus.req_valid = NREQ'(1) << id;
    bus.req_data = (NREQ * WIDTH)'(w) << (id * WIDTH);
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    rdy = bus.req_ready;
    @(posedge clock);
    #1 bus.req_valid = '0;
    lat = 1;
    while (lat < 40) begin
      @(negedge clock);
      if (bus.rsp_valid) break;
      @(posedge clock);
      #1 lat++;
    end
    rid = bus.rsp_id;
    rcnt = bus.rsp_count;
    @(posedge clock);
    #1 lg = id;
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge clock);
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    bus.req_valid = '1;
    bus.req_data = '1;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0000 ||
        bus.rsp_id !== 2'd0 || bus.rsp_count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset: busy=%b rsp_valid=%b req_ready=%b id=%0d count=%0d, required all zero",
               busy, bus.rsp_valid, bus.req_ready, bus.rsp_id, bus.rsp_count);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    bus.req_valid = '0;
  endtask
  task automatic test_directed;
    logic [WIDTH-1:0] dw [5];
    int dc [5];
    logic [NREQ-1:0] rdy;
    int lat;
    logic [1:0] rid;
    logic [3:0] rcnt;
    dw = '{8'b1001_0010, 8'b1001_1001, 8'b0000_0000, 8'b1111_1111, 8'b0000_1001};
    dc = '{2, 2, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      scan(0, dw[i], rdy, lat, rid, rcnt);
      vectors++;
      if (rdy !== 4'b0001 || lat !== 11 || rid !== 2'd0 || rcnt !== 4'(dc[i])) begin
        miscompares++;
        $display("FAIL directed[%0d] word=%b: ready=%b lat=%0d id=%0d count=%0d, required ready=0001 lat=11 id=0 count=%0d",
                 i, dw[i], rdy, lat, rid, rcnt, dc[i]);
      end
    end
  endtask
  task automatic test_cross_word;
    logic [NREQ-1:0] rdy;
    int lat;
    logic [1:0] rid;
    logic [3:0] rcnt;
    scan(1, 8'b0000_0100, rdy, lat, rid, rcnt);
    vectors++;
    if (rdy !== 4'b0010 || rid !== 2'd1 || rcnt !== 4'd0) begin
      miscompares++;
      $display("FAIL cross_word_a: ready=%b id=%0d count=%0d, required ready=0010 id=1 count=0", rdy, rid, rcnt);
    end
    scan(1, 8'b1000_0000, rdy, lat, rid, rcnt);
    vectors++;
    if (rdy !== 4'b0010 || rid !== 2'd1 || rcnt !== 4'd0) begin
      miscompares++;
      $display("FAIL cross_word_b: ready=%b id=%0d count=%0d, required ready=0010 id=1 count=0", rdy, rid, rcnt);
    end
  endtask
  task automatic test_random;
    logic [NREQ-1:0] rdy;
    int lat, id;
    logic [1:0] rid;
    logic [3:0] rcnt;
    logic [WIDTH-1:0] w;
    for (int i = 0; i < 12; i++) begin
      id = int'($urandom_range(0, NREQ - 1));
      w = WIDTH'($urandom);
      scan(id, w, rdy, lat, rid, rcnt);
      vectors++;
      if (rdy !== (NREQ'(1) << id) || lat !== WIDTH + 3 || rid !== 2'(id) || rcnt !== 4'(ref_count(w))) begin
        miscompares++;
        $display("FAIL random[%0d] word=%b: ready=%b lat=%0d id=%0d count=%0d, required id=%0d lat=%0d count=%0d",
                 i, w, rdy, lat, rid, rcnt, id, WIDTH + 3, ref_count(w));
      end
    end
  endtask
  task automatic test_round_robin;
    logic [WIDTH-1:0] words [NREQ];
    int q_id [$];
    int q_cnt [$];
    int cyc = 0, last_cyc = 0, ngrant = 0, nrsp = 0, exp_id, eid, ecnt;
    bit upd;
    for (int k = 0; k < NREQ; k++) words[k] = WIDTH'($urandom);
    bus.req_data = {words[3], words[2], words[1], words[0]};
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    while (nrsp < 8 && cyc < 200) begin
      upd = 1'b0;
      exp_id = 0;
      @(negedge clock);
      if (bus.req_ready !== 4'b0000) begin
        exp_id = (lg + 1) % NREQ;
        vectors++;
        if (bus.req_ready !== (NREQ'(1) << exp_id) || (ngrant > 0 && cyc - last_cyc != WIDTH + 4)) begin
          miscompares++;
          $display("FAIL rr_grant[%0d]: ready=%b gap=%0d, required ready=%b gap=%0d",
                   ngrant, bus.req_ready, cyc - last_cyc, NREQ'(1) << exp_id, WIDTH + 4);
        end
        q_id.push_back(exp_id);
        q_cnt.push_back(ref_count(words[exp_id]));
        lg = exp_id;
        last_cyc = cyc;
        ngrant++;
        upd = 1'b1;
      end
      if (bus.rsp_valid) begin
        eid = q_id.size() > 0 ? q_id.pop_front() : -1;
        ecnt = q_cnt.size() > 0 ? q_cnt.pop_front() : -1;
        vectors++;
        if (int'(bus.rsp_id) != eid || int'(bus.rsp_count) != ecnt) begin
          miscompares++;
          $display("FAIL rr_rsp[%0d]: id=%0d count=%0d, required id=%0d count=%0d",
                   nrsp, bus.rsp_id, bus.rsp_count, eid, ecnt);
        end
        nrsp++;
      end
      @(posedge clock);
      #1;
      if (upd) begin
        words[exp_id] = WIDTH'($urandom);
        bus.req_data = {words[3], words[2], words[1], words[0]};
      end
      if (nrsp >= 8) bus.req_valid = '0;
      cyc++;
    end
    bus.req_valid = '0;
    vectors++;
    if (nrsp != 8) begin
      miscompares++;
      $display("FAIL rr_done: responses=%0d, required 8 within 200 cycles", nrsp);
    end
  endtask
  task automatic test_backpressure;
    logic [WIDTH-1:0] w1, w2;
    int n, bad;
    w1 = 8'b1001_1001;
    w2 = WIDTH'($urandom);
    bus.req_data = {8'h00, w2, w1, 8'h00};
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    @(negedge clock);
    vectors++;
    if (bus.req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_grant: ready=%b, required 0010", bus.req_ready);
    end
    @(posedge clock);
    #1 bus.req_valid = 4'b0100;
    lg = 1;
    wait_rsp(n);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_count !== 4'd2 ||
          bus.req_ready !== 4'b0000 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: rsp_valid=%b id=%0d count=%0d ready=%b busy=%b, required 1 1 2 0000 1",
                 i, bus.rsp_valid, bus.rsp_id, bus.rsp_count, bus.req_ready, busy);
      end
      if (i < 19) @(negedge clock);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    vectors++;
    if (bus.req_ready !== 4'b0100 || bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: ready=%b rsp_valid=%b, required ready=0100 rsp_valid=0", bus.req_ready, bus.rsp_valid);
    end
    @(posedge clock);
    #1 bus.req_valid = '0;
    lg = 2;
    wait_rsp(n);
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd2 || int'(bus.rsp_count) != ref_count(w2)) begin
      miscompares++;
      $display("FAIL bp_next: rsp_valid=%b id=%0d count=%0d, required 1 id=2 count=%0d",
               bus.rsp_valid, bus.rsp_id, bus.rsp_count, ref_count(w2));
    end
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset_midscan;
    logic [WIDTH-1:0] w;
    int n, seen;
    w = 8'b1001_1001;
    bus.req_data = {8'h00, w, 8'h00, 8'h00};
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    vectors++;
    if (bus.req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL mid_grant: ready=%b, required 0100", bus.req_ready);
    end
    @(posedge clock);
    #1 bus.req_valid = '0;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b rsp_valid=%b, required 0 0", busy, bus.rsp_valid);
    end
    seen = 0;
    repeat (15) begin
      @(negedge clock);
      if (bus.rsp_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL mid_no_rsp: rsp_valid high %0d cycles, required 0", seen);
    end
    w = WIDTH'($urandom);
    bus.req_data = {w, w, w, w};
    @(posedge clock);
    #1 bus.req_valid = '1;
    @(negedge clock);
    vectors++;
    if (bus.req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL mid_regrant: ready=%b, required 0001", bus.req_ready);
    end
    @(posedge clock);
    #1 bus.req_valid = '0;
    wait_rsp(n);
    vectors++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || int'(bus.rsp_count) != ref_count(w)) begin
      miscompares++;
      $display("FAIL mid_after: rsp_valid=%b id=%0d count=%0d, required 1 id=0 count=%0d",
               bus.rsp_valid, bus.rsp_id, bus.rsp_count, ref_count(w));
    end
    @(posedge clock);
    #1;
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_directed();
    test_cross_word();
    test_random();
    test_round_robin();
    test_backpressure();
    test_reset_midscan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
